// File: rtl/pe_index_packer.sv
`default_nettype none
// ============================================================================
// Module      : pe_index_packer
// Description : Converts the priority encoder's left/right one-hot masks into
//               binary indices, span, zero and error flags, and buffers the
//               results in a show-ahead FIFO with a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_index_packer #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_left_i,
  input  logic [WIDTH-1:0] data_right_i,
  input  logic             data_val_i,
  output logic [IDX_W-1:0] left_idx_o,
  output logic [IDX_W-1:0] right_idx_o,
  output logic [IDX_W-1:0] span_o,
  output logic             zero_o,
  output logic             err_o,
  output logic             val_o,
  input  logic             ready_i,
  output logic [LVL_W-1:0] level_o,
  output logic             overflow_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  // Entry layout: {left_idx, right_idx, span, zero, err}
  localparam int ENT_W = 3 * IDX_W + 2;

  // --------------------------------------------------------------------------
  // Stage 1: mask to index conversion
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] l_idx_d;
  logic [IDX_W-1:0] r_idx_d;
  logic [IDX_W-1:0] span_d;
  logic             zero_d;
  logic             err_d;
  logic             l_multi;
  logic             r_multi;
  logic             l_none;
  logic             r_none;

  logic             s1_val_q;
  logic [ENT_W-1:0] s1_ent_q;

  // Combinational conversion of the incoming masks into an entry
  always_comb begin
    l_idx_d = '0;
    r_idx_d = '0;
    // Each index is the OR of the positions of every set bit, so a malformed
    // multi-hot mask still yields a deterministic value.
    for (int i = 0; i < WIDTH; i++) begin
      if (data_left_i[i])  l_idx_d = l_idx_d | IDX_W'(i);
      if (data_right_i[i]) r_idx_d = r_idx_d | IDX_W'(i);
    end
    l_multi = |(data_left_i  & (data_left_i  - WIDTH'(1)));
    r_multi = |(data_right_i & (data_right_i - WIDTH'(1)));
    l_none  = (data_left_i  == '0);
    r_none  = (data_right_i == '0);
    zero_d  = l_none & r_none;
    err_d   = l_multi | r_multi | (l_none ^ r_none) | (l_idx_d < r_idx_d);
    span_d  = (err_d | zero_d) ? '0 : (l_idx_d - r_idx_d);
    if (zero_d) begin
      l_idx_d = '0;
      r_idx_d = '0;
    end
  end

  // Stage-1 register: captures a converted entry on every input strobe
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      s1_val_q <= 1'b0;
      s1_ent_q <= '0;
    end else begin
      s1_val_q <= data_val_i;
      if (data_val_i) begin
        s1_ent_q <= {l_idx_d, r_idx_d, span_d, zero_d, err_d};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: show-ahead FIFO
  // --------------------------------------------------------------------------
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             overflow_q;
  logic             empty;
  logic             full;
  logic             rd_en;
  logic             wr_en;
  logic [ENT_W-1:0] head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en = ~empty & ready_i;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = s1_val_q & (~full | rd_en);

  // FIFO storage, pointers and the sticky overflow flag
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      // Storage is cleared so the data outputs read zero right after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= s1_ent_q;
        wr_ptr_q                <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (s1_val_q & ~wr_en) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  assign left_idx_o  = head[ENT_W-1 -: IDX_W];
  assign right_idx_o = head[2*IDX_W+1 -: IDX_W];
  assign span_o      = head[IDX_W+1 -: IDX_W];
  assign zero_o      = head[1];
  assign err_o       = head[0];
  assign val_o       = ~empty;
  assign level_o     = LVL_W'(wr_ptr_q - rd_ptr_q);
  assign overflow_o  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_index_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_index_packer
// Description : Self-checking bench for pe_index_packer; a queue-based model
//               tracks expected FIFO contents, occupancy and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_index_packer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int IDX_W = 4;
  localparam int LVL_W = 3;

  typedef struct packed {
    logic [IDX_W-1:0] l;
    logic [IDX_W-1:0] r;
    logic [IDX_W-1:0] s;
    logic             z;
    logic             e;
  } ent_t;

  logic             clk_i = 1'b0;
  logic             srst_i = 1'b1;
  logic [WIDTH-1:0] data_left_i = '0;
  logic [WIDTH-1:0] data_right_i = '0;
  logic             data_val_i = 1'b0;
  logic             ready_i = 1'b0;
  logic [IDX_W-1:0] left_idx_o;
  logic [IDX_W-1:0] right_idx_o;
  logic [IDX_W-1:0] span_o;
  logic             zero_o;
  logic             err_o;
  logic             val_o;
  logic [LVL_W-1:0] level_o;
  logic             overflow_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  ent_t m_q[$];
  bit   m_s1v     = 1'b0;
  ent_t m_s1e;
  bit   m_ovf     = 1'b0;
  bit   m_rstdone = 1'b0;

  pe_index_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .data_left_i  (data_left_i),
    .data_right_i (data_right_i),
    .data_val_i   (data_val_i),
    .left_idx_o   (left_idx_o),
    .right_idx_o  (right_idx_o),
    .span_o       (span_o),
    .zero_o       (zero_o),
    .err_o        (err_o),
    .val_o        (val_o),
    .ready_i      (ready_i),
    .level_o      (level_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Specification-level conversion of a mask pair into an expected entry
  function automatic ent_t conv(input logic [WIDTH-1:0] lm, input logic [WIDTH-1:0] rm);
    ent_t e;
    int li = 0;
    int ri = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lm[i]) li = li | i;
      if (rm[i]) ri = ri | i;
    end
    e.z = (lm == 0) && (rm == 0);
    e.e = ($countones(lm) > 1) || ($countones(rm) > 1) ||
          ((lm == 0) != (rm == 0)) || (li < ri);
    e.s = (e.e || e.z) ? 4'd0 : 4'((li - ri) % WIDTH);
    e.l = e.z ? 4'd0 : 4'(li);
    e.r = e.z ? 4'd0 : 4'(ri);
    return e;
  endfunction

  // Compare DUT against model, then apply one cycle of stimulus.
  // Called just after a falling edge.
  task automatic step(input bit rst, input bit dv, input bit rdy,
                      input logic [WIDTH-1:0] lm, input logic [WIDTH-1:0] rm);
    bit pop;
    check("val", 32'(val_o), 32'(m_q.size() > 0));
    check("level", 32'(level_o), 32'(m_q.size()));
    check("overflow", 32'(overflow_o), 32'(m_ovf));
    if (m_q.size() > 0) begin
      check("left_idx", 32'(left_idx_o), 32'(m_q[0].l));
      check("right_idx", 32'(right_idx_o), 32'(m_q[0].r));
      check("span", 32'(span_o), 32'(m_q[0].s));
      check("zero", 32'(zero_o), 32'(m_q[0].z));
      check("err", 32'(err_o), 32'(m_q[0].e));
    end else if (m_rstdone) begin
      check("rst_data", 32'({left_idx_o, right_idx_o, span_o, zero_o, err_o}), 32'd0);
    end

    srst_i       = rst;
    data_val_i   = dv;
    ready_i      = rdy;
    data_left_i  = lm;
    data_right_i = rm;

    if (rst) begin
      m_q.delete();
      m_s1v     = 1'b0;
      m_ovf     = 1'b0;
      m_rstdone = 1'b1;
    end else begin
      m_rstdone = 1'b0;
      pop = (m_q.size() > 0) && rdy;
      if (pop) void'(m_q.pop_front());
      if (m_s1v) begin
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(m_s1e);
      end
      m_s1v = dv;
      if (dv) m_s1e = conv(lm, rm);
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, '0, '0);
  endtask

  task automatic send(input logic [WIDTH-1:0] lm, input logic [WIDTH-1:0] rm, input bit rdy);
    step(1'b0, 1'b1, rdy, lm, rm);
  endtask

  function automatic logic [WIDTH-1:0] onehot(input int i);
    logic [WIDTH-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [WIDTH-1:0] lm;
    logic [WIDTH-1:0] rm;
    int               kind;
    int               ri;
    @(negedge clk_i);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b1, 16'h0080, 16'h0002);  // ignored under reset
    idle(2, 1'b1);

    // Single valid
    send(16'h0080, 16'h0002, 1'b1);
    idle(3, 1'b1);
    // Zero word then single bit
    send(16'h0000, 16'h0000, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);
    // Malformed pairs
    send(16'h0003, 16'h0001, 1'b1);
    send(16'h0000, 16'h0010, 1'b1);
    send(16'h0002, 16'h0008, 1'b1);
    idle(3, 1'b1);

    // Full FIFO with simultaneous read/write
    for (int i = 1; i <= 4; i++) send(onehot(i), onehot(i), 1'b0);
    idle(1, 1'b0);
    check("full_level", 32'(level_o), 32'd4);
    send(onehot(9), onehot(9), 1'b0);
    idle(1, 1'b1);                 // write of entry 9 coincides with a read
    check("full_rw_ovf", 32'(overflow_o), 32'd0);
    idle(6, 1'b1);

    // Overflow with stalled consumer
    for (int i = 1; i <= 5; i++) send(onehot(i), onehot(i), 1'b0);
    idle(2, 1'b0);
    check("ovf_level", 32'(level_o), 32'd4);
    check("ovf_flag", 32'(overflow_o), 32'd1);
    idle(6, 1'b1);

    // Reset mid-operation: 3 buffered, one in stage 1
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 1; i <= 4; i++) send(onehot(i), onehot(0), 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h0040, 16'h0004);
    idle(4, 1'b1);
    check("rst_ovf", 32'(overflow_o), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      kind = int'($urandom_range(0, 7));
      ri   = int'($urandom_range(0, WIDTH - 1));
      case (kind)
        0:       begin lm = '0; rm = '0; end
        5:       begin lm = WIDTH'($urandom); rm = WIDTH'($urandom); end
        6:       begin lm = '0; rm = onehot(ri); end
        7:       begin lm = onehot(ri); rm = onehot(ri); end
        default: begin
          lm = onehot(int'($urandom_range(ri, WIDTH - 1)));
          rm = onehot(ri);
        end
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0), lm, rm);
    end
    idle(8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_index_packer.md
# pe_index_packer

Downstream stage of the priority encoder. Takes the registered `data_left` / `data_right` one-hot masks and their valid strobe, and converts them to binary bit indices plus a span (distance between highest and lowest set bit). Results are buffered in a small show-ahead FIFO with a valid/ready output, so a stalling consumer never stalls the encoder, which has no backpressure.

## Interface
- `WIDTH`, 16: width of the input one-hot masks; must be ≥2.
- `DEPTH`, 4: number of FIFO entries; power of two, ≥2.
- `IDX_W`, `$clog2(WIDTH)`: width of each index field (derived, not overridden).
- `clk_i` input 1: the single clock; everything is synchronous to its rising edge.
- `srst_i` input 1: reset, synchronous and active-high.
- `data_left_i` input WIDTH: one-hot of the highest set bit, or all-zero.
- `data_right_i` input WIDTH: one-hot of the lowest set bit, or all-zero.
- `data_val_i` input 1: qualifies both masks for one cycle.
- `left_idx_o` output IDX_W: binary index of the left mask.
- `right_idx_o` output IDX_W: binary index of the right mask.
- `span_o` output IDX_W: `left_idx - right_idx`.
- `zero_o` output 1: source word had no bits set.
- `err_o` output 1: malformed mask pair.
- `val_o` output 1: a FIFO head entry is presented.
- `ready_i` input 1: consumer accepts the head entry when `val_o & ready_i`.
- `level_o` output `$clog2(DEPTH+1)`: current FIFO occupancy.
- `overflow_o` output 1: sticky flag; a result was dropped.

## Operation
- **Stage 1 (convert, registered).** On `data_val_i`, compute the following and register them together with the valid bit:
  - Each index is the bitwise OR of the positions of all set bits.
  - `zero = (left==0) & (right==0)`.
  - `err` is set if any of these hold: either mask has more than one bit set; exactly one mask is zero; or `left_idx < right_idx`.
  - `span = left_idx - right_idx` in IDX_W bits. If `err` or `zero`, `span` is forced to 0.
  - If `zero`, both indices are forced to 0.
- **Stage 2 (FIFO).** A registered stage-1 valid writes the entry `{left_idx, right_idx, span, zero, err}` into the FIFO.
  - Show-ahead: the head entry drives the outputs whenever `val_o=1`.
  - Read pointer advances on `val_o & ready_i`.
- **Full FIFO.**
  - A write with no simultaneous read drops the entry, sets `overflow_o`, and leaves `level_o` unchanged.
  - A write with a simultaneous read is accepted and `level_o` stays at DEPTH.
- **Empty FIFO.** A stage-1 write goes into the FIFO. There is no same-cycle bypass.
- **Pointers.** Both are `$clog2(DEPTH)` bits plus a wrap bit. `full` and `empty` are derived from the pointers.
- **Outputs when empty.** `val_o=0`. Data outputs hold the last-read head contents, which are don't-care.
- **Ordering.** Entries leave in the same order the input strobes arrived.
- **`overflow_o`** clears only on reset.

## Timing
- **Reset values.** On `srst_i` the FIFO is flushed and stage 1 is invalidated. In-flight and buffered results are discarded. The cycle after reset:
  - `val_o=0`, `level_o=0`, `overflow_o=0`.
  - `left_idx_o`, `right_idx_o`, `span_o` are 0; `zero_o=0`, `err_o=0`.
- **Reset priority.** A `data_val_i` or `ready_i` asserted in the same cycle as `srst_i` is ignored.
- **Latency.** An input strobe sampled at edge N is registered in stage 1 at edge N, written to the FIFO at edge N+1, and `val_o=1` after edge N+1 (two-edge latency when the FIFO is empty).
- **Throughput.** One input per cycle sustained while `ready_i=1`. `level_o` then stays at ≤1.
- **`level_o` update.** Updates the cycle after each write or read edge. Simultaneous write and read leaves it unchanged.
- **`val_o` / `ready_i`.** `val_o` does not depend on `ready_i` combinationally. `ready_i` may toggle freely.

## Test plan
- **Single valid.** Drive `left=0x0080`, `right=0x0002` with `data_val_i` pulsed and `ready_i=1` → two edges later, one beat with `left_idx=7`, `right_idx=1`, `span=6`, `zero=0`, `err=0`. `level_o` returns to 0.
- **Zero word, then single bit.** Drive `left=right=0x0000` → `zero=1`, indices 0, span 0, `err=0`. Then drive `left=right=0x8000` → `left_idx=15`, `right_idx=15`, `span=0`.
- **Malformed pairs.** Each of the following gives `err=1`, `span=0`:
  - `left=0x0003`, `right=0x0001`.
  - `left=0x0000`, `right=0x0010`.
  - `left=0x0002`, `right=0x0008`.
- **Overflow with stalled consumer.** With `ready_i=0`, drive 5 consecutive strobes (indices 1..5) → `level_o` reaches 4 and `overflow_o=1`. Releasing `ready_i` yields exactly 4 beats with indices 1..4 in order, and the fifth is absent.
- **Full FIFO, simultaneous read/write.** At `level_o=4`, one cycle with both a write and `ready_i=1` → `level_o` stays 4, `overflow_o` stays 0, and the new entry appears as the last beat.
- **Reset mid-operation.** With 3 entries buffered and a strobe in stage 1, pulse `srst_i` together with `data_val_i` → next cycle all outputs are at their reset values. No stale beat appears afterwards and `overflow_o=0`.
